// File: rtl/ifu_pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ifu_pc_unit : fetch program counter; loads npc each cycle, holds on stall.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module ifu_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  output logic [31:0] pc
);

  // Power-up value matches the reset value so fetch starts at the text base.
  logic [31:0] r_pc = RESET_PC;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (!stall) begin
      r_pc <= npc;
    end
  end

  assign pc = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_ifu_pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ifu_pc_unit : directed self-checking bench for ifu_pc_unit.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_ifu_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] npc;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  ifu_pc_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .npc   (npc),
    .pc    (pc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_power_up();
    #1;
    checks++;
    if (pc !== 32'h0000_3000) begin
      errors++;
      $display("FAIL power_up: pc=%h expected=%h", pc, 32'h0000_3000);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    npc   = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (pc !== 32'h0000_3000) begin
        errors++;
        $display("FAIL reset_cycle%0d: pc=%h expected=%h", i, pc, 32'h0000_3000);
      end
    end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h0000_3004;
    exp_seq[1] = 32'h0000_3008;
    exp_seq[2] = 32'h0000_300C;
    reset = 1'b0;
    // pc is 3000 here; supply pc+4 each cycle.
    for (int i = 0; i < 2; i++) begin
      npc = exp_seq[i];
      tick();
      checks++;
      if (pc !== exp_seq[i]) begin
        errors++;
        $display("FAIL seq_fetch%0d: pc=%h expected=%h", i, pc, exp_seq[i]);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    npc   = 32'h0000_300C;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h0000_3008) begin
        errors++;
        $display("FAIL stall_hold%0d: pc=%h expected=%h", i, pc, 32'h0000_3008);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h0000_300C) begin
      errors++;
      $display("FAIL stall_release: pc=%h expected=%h", pc, 32'h0000_300C);
    end
  endtask

  task automatic test_branch();
    npc = 32'h0000_3100;
    #2;
    // No combinational path: pc must not follow npc before the edge.
    checks++;
    if (pc !== 32'h0000_300C) begin
      errors++;
      $display("FAIL no_comb_path: pc=%h expected=%h", pc, 32'h0000_300C);
    end
    tick();
    checks++;
    if (pc !== 32'h0000_3100) begin
      errors++;
      $display("FAIL branch_target: pc=%h expected=%h", pc, 32'h0000_3100);
    end
    npc = 32'h0000_0000;
    tick();
    checks++;
    if (pc !== 32'h0000_0000) begin
      errors++;
      $display("FAIL jump_zero: pc=%h expected=%h", pc, 32'h0000_0000);
    end
    npc = 32'h0000_3100;
    tick();
    checks++;
    if (pc !== 32'h0000_3100) begin
      errors++;
      $display("FAIL branch_again: pc=%h expected=%h", pc, 32'h0000_3100);
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    stall = 1'b1;
    npc   = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (pc !== 32'h0000_3000) begin
      errors++;
      $display("FAIL reset_over_stall: pc=%h expected=%h", pc, 32'h0000_3000);
    end
    // First edge after reset with stall still high must hold.
    reset = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h0000_3000) begin
      errors++;
      $display("FAIL post_reset_stall: pc=%h expected=%h", pc, 32'h0000_3000);
    end
    stall = 1'b0;
    npc   = 32'h0000_4000;
    tick();
    checks++;
    if (pc !== 32'h0000_4000) begin
      errors++;
      $display("FAIL post_reset_load: pc=%h expected=%h", pc, 32'h0000_4000);
    end
  endtask

  task automatic test_boundary();
    npc = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL top_of_range: pc=%h expected=%h", pc, 32'hFFFF_FFFC);
    end
    npc = 32'h0000_3002;
    #2;
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL boundary_delay: pc=%h expected=%h", pc, 32'hFFFF_FFFC);
    end
    tick();
    checks++;
    if (pc !== 32'h0000_3002) begin
      errors++;
      $display("FAIL misaligned: pc=%h expected=%h", pc, 32'h0000_3002);
    end
    npc = 32'hA5A5_5A5A;
    tick();
    checks++;
    if (pc !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL all_bits: pc=%h expected=%h", pc, 32'hA5A5_5A5A);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    npc   = 32'h1234_5678;
    test_power_up();
    test_reset();
    test_seq_fetch();
    test_stall();
    test_branch();
    test_reset_priority();
    test_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #10000;
    $display("FAIL watchdog: time=%0t limit=%0d", $time, 10000);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
